// File: rtl/ysyx_22040632_cache_pkg.sv
// Shared types and constants for the cache-port request arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   cache_req_t : one requester's payload at the default address/data widths
//   DEF_AW/DEF_DW : default address and data widths
package ysyx_22040632_cache_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [DEF_AW-1:0]   addr;
        logic                req;          // 1 = write, 0 = read
        logic [DEF_DW-1:0]   wdata;
        logic [DEF_DW/8-1:0] wstrb;
        logic                uncacheable;
    } cache_req_t;

endpackage

// File: rtl/ysyx_22040632_cache_arb_if.sv
// Bus bundle between NREQ requesters, the arbiter and the dcache/bypass port.
//   up_*  : per-channel request side (channel i payload at slice i)
//   dn_*  : single downstream cache request/response side
// Handshake: a requester raises up_valid with a stable payload and keeps both
// until it sees its one-cycle up_ready pulse. Downstream sees dn_valid with a
// stable payload and answers with a one-cycle dn_ready (read data alongside).
// Modports: slave = the arbiter, master = requesters plus downstream model.
interface ysyx_22040632_cache_arb_if #(
    parameter int NREQ = 2,
    parameter int AW   = ysyx_22040632_cache_pkg::DEF_AW,
    parameter int DW   = ysyx_22040632_cache_pkg::DEF_DW
);
    logic [NREQ-1:0]      up_valid;
    logic [NREQ-1:0]      up_req;
    logic [NREQ*AW-1:0]   up_addr;
    logic [NREQ*DW-1:0]   up_wdata;
    logic [NREQ*DW/8-1:0] up_wstrb;
    logic [NREQ-1:0]      up_uncacheable;
    logic [NREQ-1:0]      up_ready;
    logic [DW-1:0]        up_rdata;

    logic                 dn_valid;
    logic [AW-1:0]        dn_addr;
    logic                 dn_req;
    logic [DW-1:0]        dn_data_write;
    logic [DW-1:0]        dn_wmask;
    logic [DW/8-1:0]      dn_wmask_uncacheable;
    logic                 dn_uncacheable;
    logic                 dn_ready;
    logic [DW-1:0]        dn_data_read;

    modport slave (
        input  up_valid, up_req, up_addr, up_wdata, up_wstrb, up_uncacheable,
        output up_ready, up_rdata,
        output dn_valid, dn_addr, dn_req, dn_data_write, dn_wmask,
               dn_wmask_uncacheable, dn_uncacheable,
        input  dn_ready, dn_data_read
    );

    modport master (
        output up_valid, up_req, up_addr, up_wdata, up_wstrb, up_uncacheable,
        input  up_ready, up_rdata,
        input  dn_valid, dn_addr, dn_req, dn_data_write, dn_wmask,
               dn_wmask_uncacheable, dn_uncacheable,
        output dn_ready, dn_data_read
    );
endinterface

// File: rtl/ysyx_22040632_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : channel with highest priority this round
//   found : at least one request present
//   idx   : first requesting channel scanning upward from ptr, modulo NREQ
module ysyx_22040632_rr_pick #(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);
    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/ysyx_22040632_cache_arb.sv
// N-channel round-robin arbiter in front of one cache port.
// One transaction outstanding; the winner's payload is latched and presented
// downstream from the cycle after the grant until dn_ready.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : up_* requester channels and dn_* cache port (slave modport)
//   busy         : a transaction is outstanding (FSM is in BUSY)
//   grant_id     : current or last granted channel
// Optional build macro YSYX_22040632_CACHE_ARB_PERF_EN adds:
//   perf_grant_cnt : NREQ x 32-bit per-channel grant counters
//   perf_wait_cnt  : cycles in which some valid channel was left waiting
module ysyx_22040632_cache_arb
    import ysyx_22040632_cache_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    ysyx_22040632_cache_arb_if.slave  bus,
    output logic                      busy,
    output logic [IW-1:0]             grant_id
`ifdef YSYX_22040632_CACHE_ARB_PERF_EN
    ,
    output logic [NREQ*32-1:0]        perf_grant_cnt,
    output logic [31:0]               perf_wait_cnt
`endif
);
    // Payload record at this instance's widths.
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            req;
        logic [DW-1:0]   wdata;
        logic [DW/8-1:0] wstrb;
        logic            uncacheable;
    } req_t;

    arb_state_t       state_q, state_d;
    req_t             dn_q, pick_pay;
    logic [IW-1:0]    grant_q, rr_ptr_q, rr_next;
    logic [NREQ-1:0]  up_ready_q, pick_req;
    logic [DW-1:0]    up_rdata_q;
    logic             pick_found, do_grant, do_done;
    logic [IW-1:0]    pick_idx;

    // The channel being acknowledged still shows up_valid during its
    // up_ready cycle; masking it prevents granting the finished request again.
    assign pick_req = bus.up_valid & ~up_ready_q;
    assign rr_next  = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);

    ysyx_22040632_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Winner payload; reads carry no write data and no strobes.
    always_comb begin
        pick_pay.addr        = bus.up_addr[pick_idx*AW +: AW];
        pick_pay.req         = bus.up_req[pick_idx];
        pick_pay.wdata       = pick_pay.req ? bus.up_wdata[pick_idx*DW +: DW] : '0;
        pick_pay.wstrb       = pick_pay.req ? bus.up_wstrb[pick_idx*(DW/8) +: DW/8] : '0;
        pick_pay.uncacheable = bus.up_uncacheable[pick_idx];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found)   state_d = BUSY;
            BUSY:    if (bus.dn_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        do_grant                 = (state_q == IDLE) && pick_found;
        do_done                  = (state_q == BUSY) && bus.dn_ready;
        busy                     = (state_q == BUSY);
        grant_id                 = grant_q;
        bus.dn_valid             = (state_q == BUSY);
        bus.dn_addr              = dn_q.addr;
        bus.dn_req               = dn_q.req;
        bus.dn_data_write        = dn_q.wdata;
        bus.dn_wmask_uncacheable = dn_q.wstrb;
        bus.dn_uncacheable       = dn_q.uncacheable;
        bus.up_ready             = up_ready_q;
        bus.up_rdata             = up_rdata_q;
        bus.dn_wmask             = '0;
        for (int b = 0; b < DW/8; b++) begin
            bus.dn_wmask[b*8 +: 8] = {8{dn_q.wstrb[b]}};
        end
    end

    // Latched payload, completion pulse and round-robin pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            dn_q       <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            up_ready_q <= '0;
            up_rdata_q <= '0;
        end else begin
            up_ready_q <= '0;
            if (do_grant) begin
                dn_q    <= pick_pay;
                grant_q <= pick_idx;
            end
            if (do_done) begin
                up_ready_q[grant_q] <= 1'b1;
                up_rdata_q          <= bus.dn_data_read;
                rr_ptr_q            <= rr_next;
            end
        end
    end

`ifdef YSYX_22040632_CACHE_ARB_PERF_EN
    // A channel is waiting when valid and neither being granted now, owning
    // the outstanding transaction, nor receiving its completion pulse.
    logic [NREQ-1:0] wait_mask;

    always_comb begin
        wait_mask = bus.up_valid & ~up_ready_q;
        if (do_grant)         wait_mask = wait_mask & ~(NREQ'(1) << pick_idx);
        if (state_q == BUSY)  wait_mask = wait_mask & ~(NREQ'(1) << grant_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_grant_cnt <= '0;
            perf_wait_cnt  <= '0;
        end else begin
            if (do_grant)
                perf_grant_cnt[pick_idx*32 +: 32] <= perf_grant_cnt[pick_idx*32 +: 32] + 32'd1;
            if (|wait_mask)
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif
endmodule
